sort_result_streamer: RTL and testbench

Output-side companion of the recursive bitonic sorter. It captures the parallel sorted vector (`y`, `y_label`, `y_valid`) and emits the elements one per handshake on a valid/ready stream, element 0 first. The sorter has no back-pressure, so the block double-buffers whole sort results and flags any result it must drop.

---
 rtl/sort_stream_pkg.sv | 17 +
 rtl/sort_stream_bank.sv | 41 ++++
 rtl/sort_result_streamer.sv | 110 +++++++++++
 tb/tb_sort_result_streamer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_stream_pkg.sv
// Shared constants and helpers for the sort result streamer.
package sort_stream_pkg;

  localparam int LOG_INPUT_NUM_DEF = 4;
  localparam int DATA_WIDTH_DEF    = 8;

  // Number of elements in one sort result.
  function automatic int num_elems(input int log_n);
    return 1 << log_n;
  endfunction

  // Low bit of element i in a flattened vector of width-bit elements.
  function automatic int elem_lo(input int i, input int width);
    return i * width;
  endfunction

endpackage

// File: rtl/sort_stream_bank.sv
// One result bank: capture-enabled data, label and limit storage with a read mux on idx.
module sort_stream_bank
  import sort_stream_pkg::*;
#(
  parameter int LOG_INPUT_NUM = LOG_INPUT_NUM_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LABEL_WIDTH   = LOG_INPUT_NUM
) (
  input  logic                                   clk,
  input  logic                                   wr_en,
  input  logic [(DATA_WIDTH << LOG_INPUT_NUM)-1:0]  y,
  input  logic [(LABEL_WIDTH << LOG_INPUT_NUM)-1:0] y_label,
  input  logic [LOG_INPUT_NUM:0]                 limit_in,
  input  logic [LOG_INPUT_NUM-1:0]               idx,
  output logic [DATA_WIDTH-1:0]                  rd_data,
  output logic [LABEL_WIDTH-1:0]                 rd_label,
  output logic [LOG_INPUT_NUM:0]                 limit
);

  localparam int N = num_elems(LOG_INPUT_NUM);

  logic [DATA_WIDTH-1:0]  data_mem  [N];
  logic [LABEL_WIDTH-1:0] label_mem [N];
  logic [LOG_INPUT_NUM:0] limit_reg;

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        data_mem[i]  <= y[elem_lo(i, DATA_WIDTH) +: DATA_WIDTH];
        label_mem[i] <= y_label[elem_lo(i, LABEL_WIDTH) +: LABEL_WIDTH];
      end
      limit_reg <= limit_in;
    end
  end

  assign rd_data  = data_mem[idx];
  assign rd_label = label_mem[idx];
  assign limit    = limit_reg;

endmodule

// File: rtl/sort_result_streamer.sv
// Double-buffered streamer turning a parallel sort result into a valid/ready element stream.
// Optional macro SORT_STREAM_TOPK_EN adds a top_k input limiting the elements emitted per result.
module sort_result_streamer
  import sort_stream_pkg::*;
#(
  parameter int LOG_INPUT_NUM = LOG_INPUT_NUM_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LABEL_WIDTH   = LOG_INPUT_NUM
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [(DATA_WIDTH << LOG_INPUT_NUM)-1:0]  y,
  input  logic [(LABEL_WIDTH << LOG_INPUT_NUM)-1:0] y_label,
  input  logic                                   y_valid,
`ifdef SORT_STREAM_TOPK_EN
  input  logic [LOG_INPUT_NUM:0]                 top_k,
`endif
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [DATA_WIDTH-1:0]                  m_data,
  output logic [LABEL_WIDTH-1:0]                 m_label,
  output logic [LOG_INPUT_NUM-1:0]               m_index,
  output logic                                   m_first,
  output logic                                   m_last,
  output logic                                   busy,
  output logic                                   overflow,
  input  logic                                   ovf_clr
);

  localparam int N = num_elems(LOG_INPUT_NUM);
  typedef logic [LOG_INPUT_NUM:0] limit_t;

  logic                     wr_ptr, rd_ptr;
  logic [1:0]               count;
  logic [LOG_INPUT_NUM-1:0] idx;
  logic                     valid_r, is_last, xfer, last_xfer, capture, drop;
  limit_t                   cap_limit;

  logic [DATA_WIDTH-1:0]  bank_data  [2];
  logic [LABEL_WIDTH-1:0] bank_label [2];
  limit_t                 bank_limit [2];

`ifdef SORT_STREAM_TOPK_EN
  assign cap_limit = (top_k == '0 || top_k > limit_t'(N)) ? limit_t'(N) : top_k;
`else
  assign cap_limit = limit_t'(N);
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sort_stream_bank #(
      .LOG_INPUT_NUM(LOG_INPUT_NUM),
      .DATA_WIDTH   (DATA_WIDTH),
      .LABEL_WIDTH  (LABEL_WIDTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (capture && (wr_ptr == 1'(b))),
      .y       (y),
      .y_label (y_label),
      .limit_in(cap_limit),
      .idx     (idx),
      .rd_data (bank_data[b]),
      .rd_label(bank_label[b]),
      .limit   (bank_limit[b])
    );
  end

  assign valid_r   = (count != 2'd0);
  assign is_last   = ({1'b0, idx} == bank_limit[rd_ptr] - limit_t'(1));
  assign xfer      = valid_r && m_ready;
  assign last_xfer = xfer && is_last;
  // A full block can still accept a result when the read bank frees up this cycle.
  assign capture   = y_valid && ((count != 2'd2) || last_xfer);
  assign drop      = y_valid && !capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture)
        wr_ptr <= ~wr_ptr;
      if (xfer) begin
        if (is_last) begin
          idx    <= '0;
          rd_ptr <= ~rd_ptr;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      count <= count + {1'b0, capture} - {1'b0, last_xfer};
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // Outputs are forced to zero while empty so reset leaves no stale bank data visible.
  assign m_valid = valid_r;
  assign m_data  = valid_r ? bank_data[rd_ptr]  : '0;
  assign m_label = valid_r ? bank_label[rd_ptr] : '0;
  assign m_index = valid_r ? idx : '0;
  assign m_first = valid_r && (idx == '0);
  assign m_last  = valid_r && is_last;
  assign busy    = valid_r;

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed self-checking bench for sort_result_streamer (N=4, 8-bit data).
// Define SORT_STREAM_TOPK_EN for both bench and RTL to also exercise the top_k limit.
module tb_sort_result_streamer;

  localparam int LOG_N = 2;
  localparam int DW    = 8;
  localparam int LW    = 2;

  localparam logic [31:0] RES_A = {8'd40, 8'd30, 8'd20, 8'd10};
  localparam logic [31:0] RES_B = {8'd80, 8'd70, 8'd60, 8'd50};
  localparam logic [31:0] RES_C = {8'd120, 8'd110, 8'd100, 8'd90};
  localparam logic [7:0]  LABELS = {2'd3, 2'd2, 2'd1, 2'd0};

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   y;
  logic [7:0]    y_label;
  logic          y_valid;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_label;
  logic [LOG_N-1:0] m_index;
  logic          m_first, m_last, busy, overflow, ovf_clr;
`ifdef SORT_STREAM_TOPK_EN
  logic [LOG_N:0] top_k;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sort_result_streamer #(
    .LOG_INPUT_NUM(LOG_N),
    .DATA_WIDTH   (DW),
    .LABEL_WIDTH  (LW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .y       (y),
    .y_label (y_label),
    .y_valid (y_valid),
`ifdef SORT_STREAM_TOPK_EN
    .top_k   (top_k),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_label (m_label),
    .m_index (m_index),
    .m_first (m_first),
    .m_last  (m_last),
    .busy    (busy),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] vec, input logic vld);
    y       = vec;
    y_label = LABELS;
    y_valid = vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects n consecutive transfers with m_ready high; results of k elements each, data start+10*i.
  task automatic expectRun(input string tag, input int start, input int n, input int k);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s[%0d] valid", tag, i), 32'(m_valid), 32'd1);
      checkOutput($sformatf("%s[%0d] data", tag, i), 32'(m_data), 32'(start + 10 * i));
      checkOutput($sformatf("%s[%0d] label", tag, i), 32'(m_label), 32'(i % k));
      checkOutput($sformatf("%s[%0d] index", tag, i), 32'(m_index), 32'(i % k));
      checkOutput($sformatf("%s[%0d] first", tag, i), 32'(m_first), 32'((i % k) == 0));
      checkOutput($sformatf("%s[%0d] last", tag, i), 32'(m_last), 32'((i % k) == k - 1));
      step();
    end
  endtask

  initial begin
    int e;
    rst     = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
`ifdef SORT_STREAM_TOPK_EN
    top_k   = '0;
`endif
    applyStimulus(32'd0, 1'b0);
    #2;
    checkOutput("reset m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset m_first", 32'(m_first), 32'd0);
    checkOutput("reset m_data", 32'(m_data), 32'd0);
    #10 rst = 1'b1;
    step();

    $display("[TB] basic order");
    m_ready = 1'b1;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    expectRun("basic", 10, 4, 4);
    checkOutput("basic drained", 32'(m_valid), 32'd0);

    $display("[TB] back-pressure");
    m_ready = 1'b0;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    e = 0;
    for (int cyc = 0; cyc < 20 && e < 4; cyc++) begin
      m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      checkOutput($sformatf("bp c%0d data", cyc), 32'(m_data), 32'(10 * (e + 1)));
      checkOutput($sformatf("bp c%0d index", cyc), 32'(m_index), 32'(e));
      step();
      if (m_ready) e++;
    end
    checkOutput("bp elements", 32'(e), 32'd4);
    checkOutput("bp drained", 32'(m_valid), 32'd0);

    $display("[TB] full banks");
    m_ready = 1'b0;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(RES_B, 1'b1);
    step();
    applyStimulus(RES_C, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    checkOutput("full overflow", 32'(overflow), 32'd1);
    checkOutput("full busy", 32'(busy), 32'd1);
    checkOutput("full head", 32'(m_data), 32'd10);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checkOutput("ovf cleared", 32'(overflow), 32'd0);
    applyStimulus(RES_C, 1'b1);
    ovf_clr = 1'b1;
    step();
    applyStimulus(32'd0, 1'b0);
    checkOutput("ovf set wins", 32'(overflow), 32'd1);
    step();
    ovf_clr = 1'b0;
    checkOutput("ovf cleared again", 32'(overflow), 32'd0);
    checkOutput("stall head", 32'(m_data), 32'd10);
    m_ready = 1'b1;
    expectRun("full drain", 10, 8, 4);
    checkOutput("full drained", 32'(m_valid), 32'd0);

    $display("[TB] capture on last transfer");
    m_ready = 1'b0;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(RES_B, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    m_ready = 1'b1;
    expectRun("bnd A", 10, 3, 4);
    checkOutput("bnd last data", 32'(m_data), 32'd40);
    checkOutput("bnd last flag", 32'(m_last), 32'd1);
    applyStimulus(RES_C, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    checkOutput("bnd overflow", 32'(overflow), 32'd0);
    expectRun("bnd BC", 50, 8, 4);
    checkOutput("bnd drained", 32'(m_valid), 32'd0);
    checkOutput("bnd busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-stream");
    m_ready = 1'b1;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    checkOutput("rst e0", 32'(m_data), 32'd10);
    step();
    checkOutput("rst e1", 32'(m_data), 32'd20);
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(RES_B, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    expectRun("post rst", 50, 4, 4);
    checkOutput("post rst drained", 32'(m_valid), 32'd0);

`ifdef SORT_STREAM_TOPK_EN
    $display("[TB] top_k");
    top_k = 3'd2;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    expectRun("topk2", 10, 2, 2);
    checkOutput("topk2 drained", 32'(m_valid), 32'd0);
    top_k = 3'd0;
    applyStimulus(RES_A, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0);
    expectRun("topk0", 10, 4, 4);
    checkOutput("topk0 drained", 32'(m_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
